// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the memory-port arbiter and its surroundings:
// fetch and MEM-stage request ports, the external bus port and the stall vector.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_err;

    logic [4:0]        stall;

    // Arbiter side: consumes requests and bus responses, drives everything else
    modport master (
        input  if_req, if_addr,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  bus_ack, bus_rdata,
        output if_rdata, if_ready,
        output mem_rdata, mem_ready,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_err,
        output stall
    );

    // Environment side: pipeline requesters plus the external memory
    modport slave (
        output if_req, if_addr,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output bus_ack, bus_rdata,
        input  if_rdata, if_ready,
        input  mem_rdata, mem_ready,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_err,
        input  stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single external memory port between instruction fetch and the MEM stage,
// runs the bus handshake with an ack watchdog, and sequences pipeline stalls.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.master arb
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SERVE_MEM = 2'd1,
        ST_SERVE_IF  = 2'd2
    } state_t;

    state_t             state_r,       state_s;
    logic               last_grant_r,  last_grant_s;
    logic [CNT_W-1:0]   wdog_cnt_r,    wdog_cnt_s;
    logic               bus_req_r,     bus_req_s;
    logic               bus_we_r,      bus_we_s;
    logic [ADDR_W-1:0]  bus_addr_r,    bus_addr_s;
    logic [DATA_W-1:0]  bus_wdata_r,   bus_wdata_s;
    logic               bus_err_r,     bus_err_s;
    logic               if_ready_r,    if_ready_s;
    logic [DATA_W-1:0]  if_rdata_r,    if_rdata_s;
    logic               mem_ready_r,   mem_ready_s;
    logic [DATA_W-1:0]  mem_rdata_r,   mem_rdata_s;

    logic               mem_pending_s;
    logic               if_pending_s;
    logic               wdog_expired_s;
    logic [4:0]         stall_s;

    // A requester whose ready is high this cycle is finishing, not asking again
    assign mem_pending_s  = arb.mem_req & ~mem_ready_r;
    assign if_pending_s   = arb.if_req  & ~if_ready_r;
    assign wdog_expired_s = (wdog_cnt_r == CNT_W'(TIMEOUT - 1));

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b0;
            wdog_cnt_r   <= {CNT_W{1'b0}};
            bus_req_r    <= 1'b0;
            bus_we_r     <= 1'b0;
            bus_addr_r   <= {ADDR_W{1'b0}};
            bus_wdata_r  <= {DATA_W{1'b0}};
            bus_err_r    <= 1'b0;
            if_ready_r   <= 1'b0;
            if_rdata_r   <= {DATA_W{1'b0}};
            mem_ready_r  <= 1'b0;
            mem_rdata_r  <= {DATA_W{1'b0}};
        end else begin
            state_r      <= state_s;
            last_grant_r <= last_grant_s;
            wdog_cnt_r   <= wdog_cnt_s;
            bus_req_r    <= bus_req_s;
            bus_we_r     <= bus_we_s;
            bus_addr_r   <= bus_addr_s;
            bus_wdata_r  <= bus_wdata_s;
            bus_err_r    <= bus_err_s;
            if_ready_r   <= if_ready_s;
            if_rdata_r   <= if_rdata_s;
            mem_ready_r  <= mem_ready_s;
            mem_rdata_r  <= mem_rdata_s;
        end
    end

    // Arbitration, bus handshake and watchdog next-state logic
    always_comb begin
        state_s      = state_r;
        last_grant_s = last_grant_r;
        wdog_cnt_s   = wdog_cnt_r;
        bus_we_s     = bus_we_r;
        bus_addr_s   = bus_addr_r;
        bus_wdata_s  = bus_wdata_r;
        bus_err_s    = 1'b0;
        if_ready_s   = 1'b0;
        if_rdata_s   = if_rdata_r;
        mem_ready_s  = 1'b0;
        mem_rdata_s  = mem_rdata_r;

        case (state_r)
            ST_IDLE: begin
                // MEM has priority unless fetch is also waiting and MEM had the last turn
                if (mem_pending_s && !(if_pending_s && last_grant_r)) begin
                    state_s      = ST_SERVE_MEM;
                    last_grant_s = 1'b1;
                    wdog_cnt_s   = {CNT_W{1'b0}};
                    bus_we_s     = arb.mem_we;
                    bus_addr_s   = arb.mem_addr;
                    bus_wdata_s  = arb.mem_wdata;
                end else if (if_pending_s) begin
                    state_s      = ST_SERVE_IF;
                    last_grant_s = 1'b0;
                    wdog_cnt_s   = {CNT_W{1'b0}};
                    bus_we_s     = 1'b0;
                    bus_addr_s   = arb.if_addr;
                    bus_wdata_s  = {DATA_W{1'b0}};
                end else begin
                    state_s      = ST_IDLE;
                end
            end
            ST_SERVE_MEM: begin
                if (arb.bus_ack) begin
                    state_s     = ST_IDLE;
                    mem_ready_s = 1'b1;
                    mem_rdata_s = arb.bus_rdata;
                end else if (wdog_expired_s) begin
                    state_s     = ST_IDLE;
                    mem_ready_s = 1'b1;
                    mem_rdata_s = {DATA_W{1'b0}};
                    bus_err_s   = 1'b1;
                end else begin
                    wdog_cnt_s  = wdog_cnt_r + CNT_W'(1);
                end
            end
            ST_SERVE_IF: begin
                if (arb.bus_ack) begin
                    state_s    = ST_IDLE;
                    if_ready_s = 1'b1;
                    if_rdata_s = arb.bus_rdata;
                end else if (wdog_expired_s) begin
                    state_s    = ST_IDLE;
                    if_ready_s = 1'b1;
                    if_rdata_s = {DATA_W{1'b0}};
                    bus_err_s  = 1'b1;
                end else begin
                    wdog_cnt_s = wdog_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        bus_req_s = (state_s != ST_IDLE);
    end

    // Stall vector; gated by reset so it drops together with the registered outputs
    always_comb begin
        stall_s = 5'b00000;
        if (!rst_n) begin
            stall_s = 5'b00000;
        end else if (mem_pending_s) begin
            stall_s = 5'b01111;
        end else if (if_pending_s) begin
            stall_s = 5'b00011;
        end else begin
            stall_s = 5'b00000;
        end
    end

    assign arb.bus_req   = bus_req_r;
    assign arb.bus_we    = bus_we_r;
    assign arb.bus_addr  = bus_addr_r;
    assign arb.bus_wdata = bus_wdata_r;
    assign arb.bus_err   = bus_err_r;
    assign arb.if_ready  = if_ready_r;
    assign arb.if_rdata  = if_rdata_r;
    assign arb.mem_ready = mem_ready_r;
    assign arb.mem_rdata = mem_rdata_r;
    assign arb.stall     = stall_s;

endmodule
